// File: rtl/led_pwm_blinker_if.sv
// rtl/led_pwm_blinker_if.sv - Avalon-MM register bus of the LED PWM blinker
interface led_pwm_blinker_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_blinker.sv
// rtl/led_pwm_blinker.sv - PWM brightness and per-bit blinking applied to the PIO LED pattern
module led_pwm_blinker #(
  parameter int WIDTH            = 8,
  parameter int PRESCALE_W       = 16,
  parameter int DEFAULT_PRESCALE = 49
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    led_in,
  led_pwm_blinker_if.slave    bus,
  output logic [WIDTH-1:0]    led_out
);

  logic                  wr;
  logic                  restart;
  logic                  tick;
  logic                  frame_end;
  logic                  pwm_on;

  logic [7:0]            duty_q, duty_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [WIDTH-1:0]      blink_mask_q, blink_mask_d;
  logic [7:0]            blink_half_q, blink_half_d;

  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [7:0]            active_duty_q, active_duty_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [WIDTH-1:0]      led_out_q, led_out_d;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign restart   = wr & (bus.address == 2'd3);
  // >= rather than == so that lowering PRESCALE below the running count wraps at once
  assign tick      = (presc_cnt_q >= prescale_q);
  assign frame_end = tick & (pwm_cnt_q == 8'd254);
  assign pwm_on    = (pwm_cnt_q < active_duty_q);
  assign led_out   = led_out_q;

  always_comb begin
    duty_d       = duty_q;
    prescale_d   = prescale_q;
    blink_mask_d = blink_mask_q;
    blink_half_d = blink_half_q;
    if (wr) begin
      case (bus.address)
        2'd0: duty_d = bus.writedata[7:0];
        2'd1: prescale_d = bus.writedata[PRESCALE_W-1:0];
        2'd2: begin
          blink_mask_d = bus.writedata[WIDTH-1:0];
          blink_half_d = bus.writedata[23:16];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    presc_cnt_d   = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
    pwm_cnt_d     = pwm_cnt_q;
    active_duty_d = active_duty_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
    end
    // duty_q is still the pre-write value here, so a coincident DUTY write waits a frame
    if (frame_end) begin
      active_duty_d = duty_q;
    end

    if (blink_half_q == 8'd0) begin
      blink_cnt_d   = 8'd0;
      blink_phase_d = 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == blink_half_q - 8'd1) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end

    if (restart) begin
      presc_cnt_d   = '0;
      pwm_cnt_d     = 8'd0;
      blink_cnt_d   = 8'd0;
      blink_phase_d = 1'b1;
      active_duty_d = duty_q;
    end

    led_out_d = led_in & {WIDTH{pwm_on}} & ~(blink_mask_q & {WIDTH{~blink_phase_q}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q        <= 8'hFF;
      prescale_q    <= PRESCALE_W'(DEFAULT_PRESCALE);
      blink_mask_q  <= '0;
      blink_half_q  <= 8'd0;
      presc_cnt_q   <= '0;
      pwm_cnt_q     <= 8'd0;
      active_duty_q <= 8'hFF;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
      led_out_q     <= '0;
    end else begin
      duty_q        <= duty_d;
      prescale_q    <= prescale_d;
      blink_mask_q  <= blink_mask_d;
      blink_half_q  <= blink_half_d;
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      active_duty_q <= active_duty_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0: bus.readdata = {24'd0, duty_q};
      2'd1: bus.readdata = 32'(prescale_q);
      2'd2: bus.readdata = {8'd0, blink_half_q, 16'(blink_mask_q)};
      2'd3: bus.readdata = {16'd0, pwm_cnt_q, 7'd0, blink_phase_q};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// tb/tb_led_pwm_blinker.sv - Self-checking bench for led_pwm_blinker
module tb_led_pwm_blinker;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led_out;

  led_pwm_blinker_if bus ();

  led_pwm_blinker #(.WIDTH(8), .PRESCALE_W(16), .DEFAULT_PRESCALE(49)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_in  (led_in),
    .bus     (bus),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers
  int m_duty, m_prescale, m_mask, m_half;
  int m_pc, m_pwm, m_bc, m_ph, m_ad;
  logic [7:0] m_led;

  typedef struct {
    bit          do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_duty = 255; m_prescale = 49; m_mask = 0; m_half = 0;
    m_pc = 0; m_pwm = 0; m_bc = 0; m_ph = 1; m_ad = 255; m_led = 8'h00;
  endtask

  function automatic logic [31:0] m_read(logic [1:0] a);
    case (a)
      2'd0: return 32'(m_duty);
      2'd1: return 32'(m_prescale);
      2'd2: return 32'((m_half << 16) | m_mask);
      default: return 32'((m_pwm << 8) | m_ph);
    endcase
  endfunction

  task automatic m_step();
    bit wr, rs, tick, fe;
    logic [7:0] gate, dark;
    wr   = bus.chipselect && !bus.write_n;
    rs   = wr && (bus.address == 2'd3);
    tick = (m_pc >= m_prescale);
    fe   = tick && (m_pwm == 254);
    gate = (m_pwm < m_ad) ? 8'hFF : 8'h00;
    dark = (m_ph != 0) ? 8'h00 : m_mask[7:0];
    m_led = led_in & gate & ~dark;
    if (rs) begin
      m_pc = 0; m_pwm = 0; m_bc = 0; m_ph = 1; m_ad = m_duty;
    end else begin
      m_pc = tick ? 0 : m_pc + 1;
      if (tick) m_pwm = (m_pwm + 1) % 255;
      if (fe) m_ad = m_duty;
      if (m_half == 0) begin
        m_bc = 0; m_ph = 1;
      end else if (fe) begin
        if (m_bc == m_half - 1) begin
          m_bc = 0; m_ph = 1 - m_ph;
        end else begin
          m_bc = (m_bc + 1) % 256;
        end
      end
    end
    if (wr) begin
      case (bus.address)
        2'd0: m_duty = int'(bus.writedata[7:0]);
        2'd1: m_prescale = int'(bus.writedata[15:0]);
        2'd2: begin
          m_mask = int'(bus.writedata[7:0]);
          m_half = int'(bus.writedata[23:16]);
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    check("led_out_model", {24'd0, led_out}, {24'd0, m_led});
    check("readdata_model", bus.readdata, m_read(bus.address));
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    cycle();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(string nm, logic [1:0] a, logic [31:0] exp);
    bus.address = a;
    #1;
    check(nm, bus.readdata, exp);
  endtask

  // n cycles, optional write at index wr_at, counting outputs equal to val
  task automatic run(input int n, input int wr_at, input logic [1:0] wa, input logic [31:0] wd,
                     input logic [7:0] val, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        bus.address = wa; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = wd;
      end
      cycle();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      if (led_out == val) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] v128, v129;
    logic [31:0] wd;

    tbl[0] = '{1'b1, 2'd0, 32'h12345678, 2'd0, 32'h00000078};
    tbl[1] = '{1'b1, 2'd1, 32'hABCD1234, 2'd1, 32'h00001234};
    tbl[2] = '{1'b1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h00FF00FF};
    tbl[3] = '{1'b1, 2'd2, 32'h00030081, 2'd2, 32'h00030081};
    tbl[4] = '{1'b1, 2'd1, 32'h00000000, 2'd1, 32'h00000000};
    tbl[5] = '{1'b1, 2'd3, 32'hDEADBEEF, 2'd3, 32'h00000001};
    tbl[6] = '{1'b1, 2'd0, 32'h000000FF, 2'd0, 32'h000000FF};
    tbl[7] = '{1'b0, 2'd0, 32'h00000000, 2'd1, 32'h00000000};
    tbl[8] = '{1'b0, 2'd0, 32'h00000000, 2'd2, 32'h00030081};

    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    led_in = 8'hA5;
    m_reset();

    // Reset state
    #12;
    check("reset_led_out", {24'd0, led_out}, 32'd0);
    rd("reset_duty", 2'd0, 32'd255);
    rd("reset_prescale", 2'd1, 32'd49);
    rd("reset_status", 2'd3, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle();
    check("follow_a5", {24'd0, led_out}, 32'h000000A5);
    led_in = 8'h5A;
    cycle();
    check("follow_5a", {24'd0, led_out}, 32'h0000005A);

    // Register table
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].do_wr) bus_write(tbl[i].waddr, tbl[i].wdata);
      rd($sformatf("table_%0d", i), tbl[i].raddr, tbl[i].exp);
    end

    // Duty 128 at prescale 0: 128 high then 127 low
    led_in = 8'hFF;
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'd128);
    bus_write(2'd3, 32'd0);
    cnt = 0; v128 = 8'h00; v129 = 8'h00;
    for (int k = 1; k <= 255; k++) begin
      cycle();
      if (led_out == 8'hFF) cnt++;
      if (k == 128) v128 = led_out;
      if (k == 129) v129 = led_out;
    end
    check("duty128_high", 32'(cnt), 32'd128);
    check("duty128_edge", {16'd0, v128, v129}, 32'h0000FF00);
    run(255, -1, 2'd0, 32'd0, 8'hFF, cnt);
    check("duty128_period", 32'(cnt), 32'd128);

    // Mid-frame duty writes only affect the following frame
    run(255, 50, 2'd0, 32'd64, 8'hFF, cnt);
    check("duty_midwrite_cur", 32'(cnt), 32'd128);
    run(255, 100, 2'd0, 32'd0, 8'hFF, cnt);
    check("duty64_next", 32'(cnt), 32'd64);
    run(255, 10, 2'd0, 32'd255, 8'hFF, cnt);
    check("duty0_frame", 32'(cnt), 32'd0);
    run(255, -1, 2'd0, 32'd0, 8'hFF, cnt);
    check("duty255_frame", 32'(cnt), 32'd255);

    // Blink mask 0F, half 2
    bus_write(2'd2, 32'h0002000F);
    bus_write(2'd3, 32'd0);
    run(510, -1, 2'd0, 32'd0, 8'hFF, cnt);
    check("blink_on_phase", 32'(cnt), 32'd510);
    run(510, -1, 2'd0, 32'd0, 8'hF0, cnt);
    check("blink_off_phase", 32'(cnt), 32'd510);
    cycle();
    check("blink_back_on", {24'd0, led_out}, 32'h000000FF);
    bus_write(2'd2, 32'h0000000F);
    cycle(); cycle();
    run(600, -1, 2'd0, 32'd0, 8'hFF, cnt);
    check("blink_half0_steady", 32'(cnt), 32'd600);

    // Lowering PRESCALE below the running count
    bus_write(2'd1, 32'd1000);
    bus_write(2'd3, 32'd0);
    run(600, -1, 2'd0, 32'd0, 8'hFF, cnt);
    bus_write(2'd1, 32'd10);
    rd("presc_before", 2'd3, 32'h00000001);
    cycle();
    rd("presc_wrap_tick", 2'd3, 32'h00000101);
    for (int i = 0; i < 10; i++) cycle();
    rd("presc_hold_10", 2'd3, 32'h00000101);
    cycle();
    rd("presc_tick_11", 2'd3, 32'h00000201);

    // RESTART coincident with frame_end, then the same frame_end without it
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'h0001000F);
    bus_write(2'd3, 32'd0);
    run(254, -1, 2'd0, 32'd0, 8'hFF, cnt);
    rd("pre_frame_end", 2'd3, 32'h0000FE01);
    bus_write(2'd3, 32'd0);
    rd("restart_at_frame_end", 2'd3, 32'h00000001);
    run(255, -1, 2'd0, 32'd0, 8'hFF, cnt);
    rd("frame_end_toggle", 2'd3, 32'h00000000);

    // Asynchronous reset mid-frame
    run(30, -1, 2'd0, 32'd0, 8'hFF, cnt);
    check("pre_reset_led", {24'd0, led_out}, 32'h000000F0);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    check("async_reset_led", {24'd0, led_out}, 32'd0);
    rd("rst_duty", 2'd0, 32'd255);
    rd("rst_prescale", 2'd1, 32'd49);
    rd("rst_blink", 2'd2, 32'd0);
    @(posedge clk); #1;
    rd("rst_status", 2'd3, 32'd1);
    reset_n = 1'b1;
    cycle();
    check("post_reset_follow", {24'd0, led_out}, 32'h000000FF);

    // Randomised traffic against the model
    for (int i = 0; i < 8000; i++) begin
      led_in = 8'($urandom());
      bus.address = 2'($urandom_range(0, 3));
      bus.chipselect = ($urandom_range(0, 3) == 0);
      bus.write_n = 1'b1;
      if ($urandom_range(0, 19) == 0 && (bus.address != 2'd3 || $urandom_range(0, 9) == 0)) begin
        bus.chipselect = 1'b1;
        bus.write_n = 1'b0;
        case (bus.address)
          2'd1: wd = ($urandom() & 32'hFFFF0000) | 32'($urandom_range(0, 3));
          2'd2: wd = ($urandom() & 32'hFF00FF00) |
                     {8'h00, 8'($urandom_range(0, 3)), 8'h00, 8'($urandom())};
          default: wd = $urandom();
        endcase
        bus.writedata = wd;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
